// File: rtl/key_remap_writer_if.sv
// Write port between the key remap sequencer and the note-key remap RAM.
interface key_remap_writer_if #(
    parameter int NOTE_KEY_BITS = 7
);
    logic                     ram_rw;
    logic [NOTE_KEY_BITS-1:0] ram_addr;
    logic [NOTE_KEY_BITS-1:0] ram_in;

    modport master (output ram_rw, output ram_addr, output ram_in);
    modport slave  (input  ram_rw, input  ram_addr, input  ram_in);
endinterface

// File: rtl/key_remap_writer.sv
// Interactive sequencer: walks the note slots, debounces and validates one
// physical key per slot, and writes it into the remap RAM.
module key_remap_writer #(
    parameter int NOTE_KEY_BITS = 7,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NOTE_KEY_BITS-1:0] key_in,
    key_remap_writer_if.master       ram,
    output logic                     busy,
    output logic [2:0]               slot,
    output logic                     err,
    output logic                     done
);
    localparam int                     CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]       LAST_CNT  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]             LAST_SLOT = 3'(NOTE_KEY_BITS - 1);
    localparam logic [NOTE_KEY_BITS-1:0] ONE     = NOTE_KEY_BITS'(1);

    typedef enum logic [2:0] {IDLE, WAIT_KEY, WRITE, WAIT_RELEASE, DONE} state_t;

    state_t                   state, next_state;
    logic [NOTE_KEY_BITS-1:0] key_s1, key_s2, key_stable, used;
    logic                     start_s1, start_s2, start_d, abort_s1, abort_s2;
    logic [CNT_W-1:0]         cnt;
    logic                     rw_q, rw_d, busy_d, done_d, err_d;
    logic [NOTE_KEY_BITS-1:0] addr_q, addr_d, data_q, data_d;
    logic                     start_rise, key_zero, key_multi, key_dup;

    assign start_rise = start_s2 & ~start_d;
    assign key_zero   = (key_stable == '0);
    assign key_multi  = ((key_stable & (key_stable - ONE)) != '0);
    assign key_dup    = ((key_stable & used) != '0);

    assign ram.ram_rw   = rw_q;
    assign ram.ram_addr = addr_q;
    assign ram.ram_in   = data_q;

    // Two-flop synchronizers for the raw buttons and keys, plus start edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= '0;
            key_s2   <= '0;
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            abort_s1 <= 1'b0;
            abort_s2 <= 1'b0;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            abort_s1 <= abort;
            abort_s2 <= abort_s1;
        end
    end

    // Debounce: the counter restarts on the edge where the synchronized key
    // changes, so a new value is accepted STABLE_CYCLES edges after it lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            key_stable <= '0;
        end else begin
            if (key_s1 != key_s2)
                cnt <= '0;
            else if (cnt != LAST_CNT)
                cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT)
                key_stable <= key_s2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; abort overrides everything except a write already on the bus.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (start_rise && !abort_s2) next_state = WAIT_KEY;
            WAIT_KEY:     if (abort_s2) next_state = IDLE;
                          else if (!key_zero && !key_multi && !key_dup) next_state = WRITE;
            WRITE:        next_state = abort_s2 ? IDLE : WAIT_RELEASE;
            WAIT_RELEASE: if (abort_s2) next_state = IDLE;
                          else if (key_zero) next_state = (slot == LAST_SLOT) ? DONE : WAIT_KEY;
            DONE:         next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        rw_d   = (next_state == WRITE);
        addr_d = rw_d ? (ONE << slot) : '0;
        data_d = rw_d ? key_stable : '0;
        busy_d = (next_state == WAIT_KEY) || (next_state == WRITE) ||
                 (next_state == WAIT_RELEASE);
        done_d = (next_state == DONE);
        err_d  = (state == WAIT_KEY) && !abort_s2 && !key_zero && (key_multi || key_dup);
    end

    // Registered outputs, slot index and the session's used-key mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            slot   <= '0;
            used   <= '0;
        end else begin
            rw_q   <= rw_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy   <= busy_d;
            done   <= done_d;
            err    <= err_d;
            if (state == IDLE && next_state == WAIT_KEY) begin
                slot <= '0;
                used <= '0;
            end
            if (state == WRITE)
                used <= used | data_q;
            if (state == WAIT_RELEASE && next_state == WAIT_KEY)
                slot <= slot + 3'd1;
        end
    end
endmodule

// File: tb/tb_key_remap_writer.sv
// Randomized scoreboard bench for key_remap_writer with STABLE_CYCLES=4.
module tb_key_remap_writer;
    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [6:0] key_in;
    logic       busy, err, done;
    logic [2:0] slot;

    key_remap_writer_if #(.NOTE_KEY_BITS(7)) ram_if ();

    key_remap_writer #(.NOTE_KEY_BITS(7), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
        .ram(ram_if.master), .busy(busy), .slot(slot), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [13:0] exp_q[$];
    int          exp_done = 0;

    // Reference session model: which slot is next and which keys are taken.
    bit          m_active = 1'b0;
    int          m_slot   = 0;
    logic [6:0]  m_used   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_onehot(input logic [6:0] k);
        int c = 0;
        for (int i = 0; i < 7; i++) c += int'(k[i]);
        return c == 1;
    endfunction

    // Apply one key press to the model; queue the write it should cause.
    task automatic model_press(input logic [6:0] k, output bit exp_err);
        logic [6:0] a;
        exp_err = m_active && (k != 0) && (!is_onehot(k) || (k & m_used) != 0);
        if (m_active && is_onehot(k) && (k & m_used) == 0) begin
            a = 7'b1 << m_slot;
            exp_q.push_back({a, k});
            m_used |= k;
            if (m_slot == 6) begin
                exp_done++;
                m_active = 1'b0;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic press(input logic [6:0] k, input int bounce);
        bit e;
        bit was_active = m_active;
        int slot_before = m_slot;
        for (int i = 0; i < 2 * bounce; i++) begin
            key_in = (i % 2 == 0) ? k : 7'b0;
            tick($urandom_range(1, 2));
        end
        model_press(k, e);
        key_in = k;
        tick(12);
        chk("err", err, e);
        if (was_active) chk("slot", slot, slot_before);
        chk("pending_writes", exp_q.size(), 0);
        key_in = '0;
        tick(12);
        chk("done_pending", exp_done, 0);
    endtask

    task automatic start_session();
        if (!m_active) begin
            m_active = 1'b1;
            m_slot   = 0;
            m_used   = '0;
        end
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(4);
        chk("start_busy", busy, 1);
        chk("start_slot", slot, m_slot);
    endtask

    task automatic do_abort();
        int n = 0;
        abort = 1'b1;
        while (busy && n < 10) begin
            tick(1);
            n++;
        end
        vectors++;
        if (busy || n > 3) begin
            errors++;
            $display("FAIL abort_busy_fall: busy=%0b after %0d cycles, required 0 within 3", busy, n);
        end
        m_active = 1'b0;
        tick(4);
        abort = 1'b0;
        tick(4);
        chk("abort_err", err, 0);
    endtask

    // Monitor: every write and done pulse the DUT presents is checked against the queue.
    always @(negedge clk) begin
        logic [13:0] e;
        if (ram_if.ram_rw) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: addr=%b data=%b, required no write",
                         ram_if.ram_addr, ram_if.ram_in);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", ram_if.ram_addr, e[13:7]);
                chk("write_data", ram_if.ram_in, e[6:0]);
            end
        end
        if (done) begin
            vectors++;
            if (exp_done > 0) exp_done--;
            else begin
                errors++;
                $display("FAIL unexpected_done: done=1, required 0");
            end
        end
    end

    initial begin
        logic [6:0] keys[7];
        logic [6:0] seq1[7];
        logic [6:0] tmp, kk;
        bit         e;
        int         n, j, a, b;

        seq1[0] = 7'b0000100; seq1[1] = 7'b0000001; seq1[2] = 7'b1000000;
        seq1[3] = 7'b0000010; seq1[4] = 7'b0010000; seq1[5] = 7'b0001000;
        seq1[6] = 7'b0100000;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; key_in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rw", ram_if.ram_rw, 0);
        chk("rst_addr", ram_if.ram_addr, 0);
        chk("rst_in", ram_if.ram_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot", slot, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Full session with the directed key order.
        start_session();
        for (int i = 0; i < 7; i++) press(seq1[i], 0);
        chk("session_busy", busy, 0);

        // Bounce then hold: single write, 2+4+1 cycles after the hold begins.
        start_session();
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 0) ? 7'b0000100 : 7'b0;
            tick(2);
        end
        model_press(7'b0000100, e);
        key_in = 7'b0000100;
        n = 0;
        while (!ram_if.ram_rw && n < 20) begin
            tick(1);
            n++;
        end
        chk("bounce_latency", n, 7);
        tick(6);
        key_in = '0;
        tick(12);
        do_abort();

        // Chord and duplicate rejection.
        start_session();
        press(7'b0000011, 0);
        press(7'b0000001, 0);
        press(7'b0000001, 0);
        chk("dup_slot", slot, 1);
        press(7'b0000010, 0);
        do_abort();

        // Abort after three writes, then a fresh session reuses a key at slot 0.
        start_session();
        press(7'b0100000, 1);
        press(7'b0000001, 0);
        press(7'b0001000, 2);
        do_abort();
        chk("abort_slot_busy", busy, 0);
        start_session();
        press(7'b0100000, 0);
        do_abort();

        // Asynchronous reset while waiting for release.
        start_session();
        model_press(7'b0010000, e);
        key_in = 7'b0010000;
        tick(12);
        chk("pre_reset_writes", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rw", ram_if.ram_rw, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_slot", slot, 0);
        chk("mid_rst_err", err, 0);
        m_active = 1'b0;
        key_in = '0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        press(7'b0000001, 0);
        chk("post_reset_busy", busy, 0);

        // Start pulse during a session at slot 3 changes nothing.
        start_session();
        for (int i = 0; i < 3; i++) press(seq1[i], 0);
        start_session();
        for (int i = 3; i < 7; i++) press(seq1[i], 0);
        chk("restart_ignored_busy", busy, 0);

        // Random sessions: shuffled keys interleaved with chords and duplicates.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 7; i++) keys[i] = 7'b1 << i;
            for (int i = 6; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = keys[i]; keys[i] = keys[j]; keys[j] = tmp;
            end
            start_session();
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 9) < 3) begin
                    if (i > 0 && $urandom_range(0, 1) == 1) begin
                        kk = keys[$urandom_range(0, i - 1)];
                    end else begin
                        a = $urandom_range(0, 6);
                        b = (a + 1 + $urandom_range(0, 5)) % 7;
                        kk = (7'b1 << a) | (7'b1 << b);
                    end
                    press(kk, 0);
                end
                press(keys[i], $urandom_range(0, 3));
            end
            chk("rand_session_busy", busy, 0);
        end

        tick(10);
        chk("final_queue", exp_q.size(), 0);
        chk("final_done", exp_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/key_remap_writer.md
Name: key_remap_writer

Overview:
- Interactive configuration sequencer that sits directly upstream of the note-key remap RAM and drives its rw/addr/in write port.
- Walks the 7 note slots in order. For each slot it waits for the user to press one physical key, debounces it, validates it and writes it into the RAM as that slot's mapping.
- Rejects chords (non-one-hot values) and keys already assigned in the current session.

Parameters:
- NOTE_KEY_BITS, 7, width of the one-hot key vector and the number of slots.
- STABLE_CYCLES, 1000000, consecutive clk cycles a synchronized key value must hold before it is accepted (10 ms at 100 MHz); benches use 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  raw button level; its rising edge begins a session.
- abort  in  1  raw button level; while high it cancels a session.
- key_in  in  NOTE_KEY_BITS  raw key switches, asynchronous to clk.
- ram_rw  out  1  write strobe to the RAM.
- ram_addr  out  NOTE_KEY_BITS  one-hot slot address to the RAM.
- ram_in  out  NOTE_KEY_BITS  key written to the addressed slot.
- busy  out  1  high while a session is active.
- slot  out  3  index of the slot being configured, 0..6.
- err  out  1  high while the debounced key is invalid.
- done  out  1  one-cycle pulse when all 7 slots are written.

Behaviour:
- Reset (async on rst_n low, released synchronously on clk):
  - state IDLE; ram_rw=0, ram_addr=0, ram_in=0, busy=0, slot=0, err=0, done=0.
  - used mask, synchronizers, debounce counter and key_stable all cleared.
  - The RAM resets to identity on the same rst_n.
  - Reset mid-session discards the session; entries already written are restored to identity by the RAM reset.
- Input conditioning:
  - key_in, start and abort each pass through a 2-flop synchronizer.
  - start is edge-detected on its synchronized value.
  - Debounce: the counter resets whenever the synchronized key differs from the previous cycle's value. When it reaches STABLE_CYCLES-1, key_stable loads the synchronized value on the next edge.
- State machine:
  - IDLE: busy=0. A start rising edge moves to WAIT_KEY with slot=0 and the used mask cleared.
  - WAIT_KEY:
    - key_stable==0: stay, err=0.
    - key_stable has more than one bit set: stay, err=1.
    - key_stable is one-hot and (key_stable & used)!=0: stay, err=1 (duplicate).
    - key_stable is one-hot and unused: go to WRITE, err=0.
  - WRITE: exactly one cycle with ram_rw=1, ram_addr=(1<<slot), ram_in=key_stable. The used mask ORs in key_stable. Next state is WAIT_RELEASE.
  - WAIT_RELEASE: wait for key_stable==0. If slot==6, go to DONE; otherwise slot+1 and go to WAIT_KEY.
  - DONE: done=1 for one cycle, then IDLE. busy=0 from the IDLE cycle onward.
- Outside WRITE: ram_rw=0, ram_addr=0, ram_in=0. The write port is registered and glitch-free.
- busy=1 in WAIT_KEY, WRITE and WAIT_RELEASE.
- Latency: from a stable key_in change to the ram_rw pulse is 2 (synchronizer) + STABLE_CYCLES + 1 (FSM) cycles.
- Boundary conditions:
  - start edge while busy: ignored.
  - Synchronized abort high in any non-IDLE state: next state is IDLE. No further writes; slots already written keep their values. done does not pulse and err clears.
  - abort and WRITE in the same cycle: the write completes, then the block goes to IDLE.
  - start and abort simultaneous in IDLE: abort wins, stay IDLE.
  - A key held through WRITE is not rewritten to the next slot; WAIT_RELEASE requires a release first.
  - A chord that collapses to a single unused key: accepted once that value has been stable for STABLE_CYCLES.
  - slot never exceeds 6 and does not wrap.

Test Plan:
1. Full session, STABLE_CYCLES=4: start, then press and release keys 0000100, 0000001, 1000000, 0000010, 0010000, 0001000, 0100000 in turn. Response: 7 single-cycle ram_rw pulses with ram_addr 0000001..1000000 and the matching ram_in values, then one done pulse; busy returns to 0.
2. Bounce: key_in toggles 0000100/0 every 2 cycles for 20 cycles, then holds 0000100. Response: no ram_rw during toggling; exactly one write of 0000100 exactly 7 cycles (2+4+1) after the final hold begins.
3. Chord and duplicate: key_in=0000011 held gives err=1 with no write. Slot 0 written with 0000001; pressing 0000001 again at slot 1 gives err=1, no write, slot stays 1. Pressing 0000010 gives err=0 and a write to addr 0000010.
4. Abort after 3 writes: busy falls within 3 cycles, no further ram_rw, no done pulse. A new start restarts at slot=0 with the used mask cleared.
5. rst_n asserted low mid-WAIT_RELEASE, with no clk edge: all outputs 0 immediately. After release the block stays IDLE until a new start edge.
6. start pulsed during an active session at slot 3: slot stays 3, the session continues unchanged and no extra write occurs.
